lw_sha_padder: RTL and testbench
================================

Name: lw_sha_padder

Overview:
Host-side message source for lw_sha_main / lw_hmac. It accepts a raw big-endian message word stream with byte-granular end, and emits fully padded SHA blocks on the core's start/data_valid/last/ready stream. Padding is a 0x80 terminator, zero fill, and the message bit-length in the last two words. A one-block buffer lets last_o be known before a block's first word is emitted.

Parameters:
WORD_SIZE, 32, datapath width; 32 = SHA-224/256 framing, 64 = SHA-384/512 framing.
BLOCK_WORDS, 16, words per SHA block; fixed, not overridable.

Ports:
clk_i  in  1  clock.
reset_i  in  1  synchronous reset, active-high (one clock; reset is synchronous and active-high).
abort_i  in  1  drop the current message; return to IDLE.
in_valid_i  in  1  in_data_i is valid.
in_ready_o  out  1  padder accepts a word.
in_data_i  in  WORD_SIZE  message word, big-endian, MSB-aligned.
in_last_i  in  1  final message word.
in_bytes_i  in  $clog2(WORD_SIZE/8)+1  valid bytes in the last word, 0..WORD_SIZE/8; ignored unless in_last_i.
start_o  out  1  first word of the message's first block.
data_o  out  WORD_SIZE  padded block word to the core.
data_valid_o  out  1  data_o is valid.
last_o  out  1  high for all 16 words of the final block.
ready_i  in  1  core ready; a word transfers when data_valid_o && ready_i.
done_o  out  1  one-cycle pulse after the final word transfers.

Behaviour:
- Reset values: state IDLE, in_ready_o=1, data_valid_o=0, start_o=0, last_o=0, data_o=0, done_o=0. The bit counter, buffer and indices are cleared.
- Input transfer: in_valid_i && in_ready_o.
- Bit counter: 64 bits, +8*WORD_SIZE/8 per full word, +8*in_bytes_i on the last word. Wraps mod 2^64 with no error flag.
- States: IDLE, FILL, DRAIN, EXTRA.
- IDLE/FILL: in_ready_o=1. Words are written into buffer index w=0..15.
- 16th word without last (w=15): go to DRAIN with final=0.
- Word with in_last_i:
  - Bytes beyond in_bytes_i are zeroed.
  - Terminator position: p=w if in_bytes_i<WORD_SIZE/8, else p=w+1. If in_bytes_i<WORD_SIZE/8, 0x80 is written at byte in_bytes_i of word w; words p+1..15 are zeroed.
  - p<=13: 0x80 goes at word p (if p>w). Words 14/15 get the length field. final=1.
  - p==14 or 15: 0x80 goes at p (if p>w). Remaining words are zero. final=0; EXTRA is queued.
  - p==16: block is unchanged, final=0; EXTRA is queued with 0x80 in word 0.
- Length field:
  - WORD_SIZE=32: word14=L[63:32], word15=L[31:0].
  - WORD_SIZE=64: word14=0, word15=L[63:0].
- DRAIN: in_ready_o=0. data_valid_o=1 starting the cycle after the fill-completing transfer. Words are read out 0..15.
  - last_o=final for the whole block.
  - start_o=1 only on word 0 of the message's first block.
  - data_o, start_o and last_o are held stable while ready_i=0.
  - After word 15 transfers: EXTRA if queued; else IDLE if final; else FILL with w=0.
- EXTRA: generated on the fly, no buffer. Word 0 = 0x80 in the MSB byte if p==16, else 0. Words 1..13 = 0. Words 14/15 = length. last_o=1, start_o=0.
- done_o pulses the cycle after word 15 of the final block transfers. The next message is accepted in the same cycle.
- Latency:
  - Message of <=13 words: first output word 1 cycle after the last input transfer.
  - With ready_i held high, a 16-word block drains in 16 cycles. No FILL/DRAIN overlap.
- abort_i: next cycle the state is IDLE, data_valid_o=0, and the counter and queued EXTRA are cleared. abort_i has priority over any transfer in the same cycle; reset_i has priority over abort_i.
- Reset mid-operation: identical to power-up reset; no partial output.
- in_valid_i while in_ready_o=0: ignored; the source must hold the word.

Decomposition:
- lw_sha_pkg additions:
  - BLOCK_WORDS=16, PAD_BYTE=8'h80.
  - typedef enum logic [1:0] {PAD_IDLE, PAD_FILL, PAD_DRAIN, PAD_EXTRA} pad_state_t.
  - Function len_word(idx, L, WORD_SIZE).
- Sub-module lw_sha_block_buf: 16 x WORD_SIZE register file, write index with byte-mask/zero-fill write, read index. Reset clears it.

Test Plan:
1. WORD_SIZE=32, "abc": 0x61626300, bytes=3, last; ready_i=1. Expect 16 words: 0x61626380, 13 x 0, 0x00000000, 0x00000018. start_o on word 0, last_o on all 16, done_o once. The core digest is ba7816bf...f20015ad.
2. Empty message: one word, bytes=0, last. Expect 0x80000000, 14 x 0, 0x00000000. last_o=1 and start_o=1 on word 0.
3. 56 bytes (14 full words, last on word 13, bytes=4). Expect block 1 = data + 0x80000000 + 0 with last_o=0. Expect block 2 = 15 x 0, then 0x000001C0, with last_o=1 and start_o=0.
4. 64 bytes: block 1 = data, last_o=0. Block 2: word 0 = 0x80000000, word 15 = 0x00000200, last_o=1. WORD_SIZE=64 "abc": word 0 = 0x6162638000000000, word 15 = 0x18.
5. ready_i random 50%: data_o/start_o/last_o are stable when not accepted; output sequence identical to test 1. in_valid_i gaps during FILL give the same result.
6. abort_i on drain word 5: next cycle data_valid_o=0, in_ready_o=1. Then "abc" gives exactly the test 1 output with a fresh start_o. reset_i mid-FILL gives the same result.

Source files
------------

// File: rtl/lw_sha_pkg.sv
// Shared constants, state type and length-field helper for the SHA message padder.
package lw_sha_pkg;

  localparam int         BLOCK_WORDS = 16;
  localparam logic [7:0] PAD_BYTE    = 8'h80;

  typedef enum logic [1:0] {
    PAD_IDLE,
    PAD_FILL,
    PAD_DRAIN,
    PAD_EXTRA
  } pad_state_t;

  // Length field word for block positions 14 (idx=0) and 15 (idx=1).
  // 32-bit framing splits the 64-bit length across both words.
  // 64-bit framing carries a 128-bit length whose upper half is always zero.
  function automatic logic [63:0] len_word(input logic idx, input logic [63:0] len,
                                           input int word_size);
    logic [63:0] res;
    res = '0;
    if (word_size == 32) begin
      res = idx ? {32'h0, len[31:0]} : {32'h0, len[63:32]};
    end else begin
      res = idx ? len : 64'h0;
    end
    return res;
  endfunction

endpackage

// File: rtl/lw_sha_block_buf.sv
// One-block word buffer: indexed write, optional terminator word just after
// the written word, and zero fill of every word beyond the written one.
module lw_sha_block_buf
  import lw_sha_pkg::*;
#(
  parameter int WORD_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [3:0]           wr_idx,
  input  logic [WORD_SIZE-1:0] wr_data,
  input  logic                 term_en,
  input  logic                 zero_fill,
  input  logic [3:0]           rd_idx,
  output logic [WORD_SIZE-1:0] rd_data
);

  localparam logic [WORD_SIZE-1:0] PAD_WORD = {PAD_BYTE, {(WORD_SIZE-8){1'b0}}};

  logic [WORD_SIZE-1:0] mem [BLOCK_WORDS];

  // Written word wins, then the terminator slot, then zero fill of the tail.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BLOCK_WORDS; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < BLOCK_WORDS; i++) begin
        if (wr_en && i == int'(wr_idx)) begin
          mem[i] <= wr_data;
        end else if (term_en && i == int'(wr_idx) + 1) begin
          mem[i] <= PAD_WORD;
        end else if (zero_fill && i > int'(wr_idx)) begin
          mem[i] <= '0;
        end
      end
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/lw_sha_padder.sv
// SHA message padder: buffers one block of message words, appends the 0x80
// terminator, zero fill and bit length, and streams padded blocks to the core.
module lw_sha_padder
  import lw_sha_pkg::*;
#(
  parameter int WORD_SIZE = 32
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          abort_i,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic [WORD_SIZE-1:0]          in_data_i,
  input  logic                          in_last_i,
  input  logic [$clog2(WORD_SIZE/8):0]  in_bytes_i,
  output logic                          start_o,
  output logic [WORD_SIZE-1:0]          data_o,
  output logic                          data_valid_o,
  output logic                          last_o,
  input  logic                          ready_i,
  output logic                          done_o
);

  localparam int NB = WORD_SIZE / 8;
  localparam logic [WORD_SIZE-1:0] PAD_WORD = {PAD_BYTE, {(WORD_SIZE-8){1'b0}}};

  pad_state_t  state_q, state_d;
  logic [3:0]  wr_idx_q, wr_idx_d;
  logic [3:0]  rd_idx_q, rd_idx_d;
  logic        final_q, final_d;
  logic        extra_q, extra_d;
  logic        extra_term_q, extra_term_d;
  logic        first_q, first_d;
  logic        done_d;
  logic [63:0] cnt_q, cnt_d;

  logic                 buf_wr_en, buf_term_en, buf_zero_fill;
  logic [WORD_SIZE-1:0] buf_wr_data, buf_rd_data;

  logic                 in_xfer, out_xfer, full_word;
  logic [4:0]           term_pos;
  logic [63:0]          add_bits;
  logic [WORD_SIZE-1:0] last_data;
  logic [63:0]          len_hi_full, len_lo_full;
  logic [WORD_SIZE-1:0] len_sel;

  lw_sha_block_buf #(.WORD_SIZE(WORD_SIZE)) u_buf (
    .clk       (clk_i),
    .reset     (reset_i),
    .wr_en     (buf_wr_en),
    .wr_idx    (wr_idx_q),
    .wr_data   (buf_wr_data),
    .term_en   (buf_term_en),
    .zero_fill (buf_zero_fill),
    .rd_idx    (rd_idx_q),
    .rd_data   (buf_rd_data)
  );

  assign in_xfer  = in_valid_i && in_ready_o;
  assign out_xfer = data_valid_o && ready_i;

  assign len_hi_full = len_word(1'b0, cnt_q, WORD_SIZE);
  assign len_lo_full = len_word(1'b1, cnt_q, WORD_SIZE);
  assign len_sel     = rd_idx_q[0] ? len_lo_full[WORD_SIZE-1:0] : len_hi_full[WORD_SIZE-1:0];

  // Final-word shaping: keep valid bytes, drop the terminator into the first
  // unused byte, clear the rest; also work out where the terminator lands.
  always_comb begin
    full_word = int'(in_bytes_i) >= NB;
    last_data = '0;
    for (int k = 0; k < NB; k++) begin
      if (full_word || k < int'(in_bytes_i)) begin
        last_data[WORD_SIZE-1-8*k -: 8] = in_data_i[WORD_SIZE-1-8*k -: 8];
      end else if (k == int'(in_bytes_i)) begin
        last_data[WORD_SIZE-1-8*k -: 8] = PAD_BYTE;
      end else begin
        last_data[WORD_SIZE-1-8*k -: 8] = 8'h00;
      end
    end
    term_pos = {1'b0, wr_idx_q} + (full_word ? 5'd1 : 5'd0);
    if (!in_last_i || full_word) add_bits = 64'(WORD_SIZE);
    else                         add_bits = 64'(in_bytes_i) << 3;
  end

  // State register and bookkeeping.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= PAD_IDLE;
      wr_idx_q     <= '0;
      rd_idx_q     <= '0;
      final_q      <= 1'b0;
      extra_q      <= 1'b0;
      extra_term_q <= 1'b0;
      first_q      <= 1'b1;
      cnt_q        <= '0;
      done_o       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_idx_q     <= wr_idx_d;
      rd_idx_q     <= rd_idx_d;
      final_q      <= final_d;
      extra_q      <= extra_d;
      extra_term_q <= extra_term_d;
      first_q      <= first_d;
      cnt_q        <= cnt_d;
      done_o       <= done_d;
    end
  end

  // Next-state logic and buffer write control; abort overrides everything.
  always_comb begin
    state_d       = state_q;
    wr_idx_d      = wr_idx_q;
    rd_idx_d      = rd_idx_q;
    final_d       = final_q;
    extra_d       = extra_q;
    extra_term_d  = extra_term_q;
    first_d       = first_q;
    cnt_d         = cnt_q;
    done_d        = 1'b0;
    buf_wr_en     = 1'b0;
    buf_term_en   = 1'b0;
    buf_zero_fill = 1'b0;
    buf_wr_data   = in_data_i;

    case (state_q)
      PAD_IDLE, PAD_FILL: begin
        if (in_xfer) begin
          buf_wr_en = 1'b1;
          cnt_d     = cnt_q + add_bits;
          if (in_last_i) begin
            buf_wr_data   = last_data;
            buf_zero_fill = 1'b1;
            buf_term_en   = full_word && (wr_idx_q != 4'd15);
            final_d       = term_pos <= 5'd13;
            extra_d       = term_pos >= 5'd14;
            extra_term_d  = term_pos == 5'd16;
            state_d       = PAD_DRAIN;
            wr_idx_d      = '0;
            rd_idx_d      = '0;
          end else if (wr_idx_q == 4'd15) begin
            final_d  = 1'b0;
            extra_d  = 1'b0;
            state_d  = PAD_DRAIN;
            wr_idx_d = '0;
            rd_idx_d = '0;
          end else begin
            wr_idx_d = wr_idx_q + 4'd1;
            state_d  = PAD_FILL;
          end
        end
      end
      PAD_DRAIN: begin
        if (out_xfer) begin
          if (rd_idx_q == 4'd0) first_d = 1'b0;
          if (rd_idx_q == 4'd15) begin
            rd_idx_d = '0;
            if (extra_q) begin
              state_d = PAD_EXTRA;
            end else if (final_q) begin
              state_d = PAD_IDLE;
              done_d  = 1'b1;
              cnt_d   = '0;
              first_d = 1'b1;
              final_d = 1'b0;
            end else begin
              state_d = PAD_FILL;
            end
          end else begin
            rd_idx_d = rd_idx_q + 4'd1;
          end
        end
      end
      PAD_EXTRA: begin
        if (out_xfer) begin
          if (rd_idx_q == 4'd15) begin
            rd_idx_d     = '0;
            state_d      = PAD_IDLE;
            done_d       = 1'b1;
            cnt_d        = '0;
            extra_d      = 1'b0;
            extra_term_d = 1'b0;
            first_d      = 1'b1;
          end else begin
            rd_idx_d = rd_idx_q + 4'd1;
          end
        end
      end
      default: state_d = PAD_IDLE;
    endcase

    if (abort_i) begin
      state_d       = PAD_IDLE;
      wr_idx_d      = '0;
      rd_idx_d      = '0;
      final_d       = 1'b0;
      extra_d       = 1'b0;
      extra_term_d  = 1'b0;
      first_d       = 1'b1;
      cnt_d         = '0;
      done_d        = 1'b0;
      buf_wr_en     = 1'b0;
      buf_term_en   = 1'b0;
      buf_zero_fill = 1'b0;
    end
  end

  // Output stream: buffered block words, length override, or generated extra block.
  always_comb begin
    in_ready_o   = (state_q == PAD_IDLE) || (state_q == PAD_FILL);
    data_valid_o = (state_q == PAD_DRAIN) || (state_q == PAD_EXTRA);
    data_o       = '0;
    start_o      = 1'b0;
    last_o       = 1'b0;
    case (state_q)
      PAD_DRAIN: begin
        data_o  = (final_q && rd_idx_q >= 4'd14) ? len_sel : buf_rd_data;
        last_o  = final_q;
        start_o = first_q && (rd_idx_q == 4'd0);
      end
      PAD_EXTRA: begin
        last_o = 1'b1;
        if (rd_idx_q == 4'd0 && extra_term_q) data_o = PAD_WORD;
        else if (rd_idx_q >= 4'd14)           data_o = len_sel;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lw_sha_padder.sv
// Self-checking bench for lw_sha_padder: reference padding model against a
// 32-bit and a 64-bit instance, plus hand-computed literal word checks.
module tb_lw_sha_padder;

  typedef logic [7:0] byte_q_t [$];
  typedef struct {
    logic [63:0] data;
    bit          start;
    bit          last;
    bit          fin;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        abort_i = 1'b0;
  logic        ready_i = 1'b1;

  logic        in_valid32 = 1'b0, in_last32 = 1'b0, in_ready32;
  logic [31:0] in_data32 = '0;
  logic [2:0]  in_bytes32 = '0;
  logic        start32, dvalid32, last32, done32;
  logic [31:0] data32;

  logic        in_valid64 = 1'b0, in_last64 = 1'b0, in_ready64;
  logic [63:0] in_data64 = '0;
  logic [3:0]  in_bytes64 = '0;
  logic        start64, dvalid64, last64, done64;
  logic [63:0] data64;

  int   total = 0;
  int   bad = 0;
  bit   rand_ready = 1'b0;

  exp_t        exp32[$], exp64[$];
  logic [63:0] cap32[$], cap64[$];
  bit          done_exp[2];
  bit          hold_v[2];
  logic [63:0] hold_d[2];
  bit          hold_s[2], hold_l[2];
  int          xfer[2];

  always #5 clk = ~clk;

  lw_sha_padder #(.WORD_SIZE(32)) dut32 (
    .clk_i(clk), .reset_i(reset_i), .abort_i(abort_i),
    .in_valid_i(in_valid32), .in_ready_o(in_ready32), .in_data_i(in_data32),
    .in_last_i(in_last32), .in_bytes_i(in_bytes32),
    .start_o(start32), .data_o(data32), .data_valid_o(dvalid32), .last_o(last32),
    .ready_i(ready_i), .done_o(done32)
  );

  lw_sha_padder #(.WORD_SIZE(64)) dut64 (
    .clk_i(clk), .reset_i(reset_i), .abort_i(abort_i),
    .in_valid_i(in_valid64), .in_ready_o(in_ready64), .in_data_i(in_data64),
    .in_last_i(in_last64), .in_bytes_i(in_bytes64),
    .start_o(start64), .data_o(data64), .data_valid_o(dvalid64), .last_o(last64),
    .ready_i(ready_i), .done_o(done64)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Standard SHA padding on a byte string, split into big-endian words.
  task automatic build_expect(input byte_q_t msg, input int ws);
    byte_q_t     p;
    int          bb, lf, nbw, nwords;
    logic [63:0] len, w;
    exp_t        e;
    bb  = 2 * ws;
    lf  = ws / 4;
    nbw = ws / 8;
    len = 64'(msg.size()) * 64'd8;
    p = msg;
    p.push_back(8'h80);
    while ((p.size() % bb) != bb - lf) p.push_back(8'h00);
    for (int i = lf - 1; i >= 0; i--) p.push_back((i < 8) ? 8'(len >> (8 * i)) : 8'h00);
    nwords = p.size() / nbw;
    for (int wi = 0; wi < nwords; wi++) begin
      w = '0;
      for (int b = 0; b < nbw; b++) w = {w[55:0], p[wi * nbw + b]};
      e.data  = w;
      e.start = (wi == 0);
      e.last  = (wi >= nwords - 16);
      e.fin   = (wi == nwords - 1);
      if (ws == 32) exp32.push_back(e);
      else          exp64.push_back(e);
    end
  endtask

  task automatic sendWord(input int ws, input logic [63:0] d, input bit last, input int bytes);
    int  budget;
    bit  rdy;
    budget = 0;
    if (ws == 32) begin
      in_valid32 = 1'b1; in_data32 = d[31:0]; in_last32 = last; in_bytes32 = 3'(bytes);
    end else begin
      in_valid64 = 1'b1; in_data64 = d; in_last64 = last; in_bytes64 = 4'(bytes);
    end
    forever begin
      @(negedge clk);
      rdy = (ws == 32) ? in_ready32 : in_ready64;
      if (rdy) break;
      budget++;
      if (budget > 300) begin
        chk("in_ready_timeout", 64'(rdy), 64'd1);
        break;
      end
    end
    @(posedge clk); #2;
    in_valid32 = 1'b0; in_last32 = 1'b0;
    in_valid64 = 1'b0; in_last64 = 1'b0;
  endtask

  // Drives a whole message (junk in unused bytes of the last word) and queues its expectation.
  task automatic applyStimulus(input byte_q_t msg, input int ws, input bit gaps);
    int          nb, nw, bytes, idx;
    bit          last;
    logic [63:0] w;
    nb = ws / 8;
    build_expect(msg, ws);
    nw = (msg.size() == 0) ? 1 : (msg.size() + nb - 1) / nb;
    for (int i = 0; i < nw; i++) begin
      w = '0;
      for (int b = 0; b < nb; b++) begin
        idx = i * nb + b;
        w = {w[55:0], (idx < msg.size()) ? msg[idx] : 8'hEE};
      end
      last  = (i == nw - 1);
      bytes = last ? (msg.size() - i * nb) : nb;
      if (gaps && $urandom_range(0, 1) == 1) begin
        @(posedge clk); #2;
      end
      sendWord(ws, w, last, bytes);
    end
    if (ws == 32 && nw <= 13) begin
      @(negedge clk);
      chk("first_word_latency", 64'(dvalid32), 64'd1);
      @(posedge clk); #2;
    end
  endtask

  task automatic waitDrain(input int lane);
    int budget;
    budget = 0;
    forever begin
      @(negedge clk);
      if ((lane == 0 ? exp32.size() : exp64.size()) == 0) break;
      budget++;
      if (budget > 600) begin
        chk("drain_timeout", 64'(lane == 0 ? exp32.size() : exp64.size()), 64'd0);
        break;
      end
    end
    @(posedge clk); #2;
    @(posedge clk); #2;
  endtask

  function automatic byte_q_t makeMsg(input int n);
    byte_q_t q;
    for (int i = 0; i < n; i++) q.push_back(8'(i * 7 + 1));
    return q;
  endfunction

  // Per-cycle check of one instance: done timing, hold stability, word contents.
  task automatic checkOutput(input int lane, input bit v, input logic [63:0] d,
                             input bit s, input bit l, input bit dn);
    exp_t e;
    bit   empty;
    chk($sformatf("done_lane%0d", lane), 64'(dn), 64'(done_exp[lane]));
    done_exp[lane] = 1'b0;
    if (hold_v[lane]) begin
      chk("hold_valid", 64'(v), 64'd1);
      chk("hold_data", d, hold_d[lane]);
      chk("hold_start", 64'(s), 64'(hold_s[lane]));
      chk("hold_last", 64'(l), 64'(hold_l[lane]));
    end
    hold_v[lane] = 1'b0;
    if (v) begin
      if (ready_i) begin
        empty = (lane == 0) ? (exp32.size() == 0) : (exp64.size() == 0);
        if (empty) begin
          total++; bad++;
          $display("[TB] FAIL unexpected_word lane%0d: got 0x%0h expected no word", lane, d);
        end else begin
          e = (lane == 0) ? exp32.pop_front() : exp64.pop_front();
          chk($sformatf("data_lane%0d", lane), d, e.data);
          chk($sformatf("start_lane%0d", lane), 64'(s), 64'(e.start));
          chk($sformatf("last_lane%0d", lane), 64'(l), 64'(e.last));
          done_exp[lane] = e.fin;
        end
        if (lane == 0) cap32.push_back(d);
        else           cap64.push_back(d);
        xfer[lane]++;
      end else begin
        hold_v[lane] = 1'b1;
        hold_d[lane] = d;
        hold_s[lane] = s;
        hold_l[lane] = l;
      end
    end
  endtask

  // Compare process: sampled on the falling edge, predicts the next rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_i || abort_i) begin
        exp32.delete(); exp64.delete();
        for (int k = 0; k < 2; k++) begin
          done_exp[k] = 1'b0;
          hold_v[k]   = 1'b0;
        end
      end else begin
        checkOutput(0, dvalid32, 64'(data32), start32, last32, done32);
        checkOutput(1, dvalid64, data64, start64, last64, done64);
      end
    end
  end

  // Core-side ready: steady high or a coin toss each cycle.
  initial begin
    forever begin
      @(posedge clk); #2;
      ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic checkIdle(input string tag);
    chk({tag, "_in_ready"}, 64'(in_ready32), 64'd1);
    chk({tag, "_data_valid"}, 64'(dvalid32), 64'd0);
    chk({tag, "_start"}, 64'(start32), 64'd0);
    chk({tag, "_last"}, 64'(last32), 64'd0);
    chk({tag, "_data"}, 64'(data32), 64'd0);
    chk({tag, "_done"}, 64'(done32), 64'd0);
  endtask

  initial begin
    byte_q_t abc;
    int      base;
    abc = '{8'h61, 8'h62, 8'h63};

    repeat (3) @(posedge clk);
    #2 reset_i = 1'b0;
    @(negedge clk);
    checkIdle("reset");
    @(posedge clk); #2;

    $display("[TB] abc, 32-bit");
    cap32.delete();
    applyStimulus(abc, 32, 1'b0);
    waitDrain(0);
    chk("abc_words", 64'(cap32.size()), 64'd16);
    chk("abc_w0", cap32[0], 64'h61626380);
    chk("abc_w14", cap32[14], 64'h0);
    chk("abc_w15", cap32[15], 64'h18);

    $display("[TB] empty message");
    cap32.delete();
    applyStimulus(makeMsg(0), 32, 1'b0);
    waitDrain(0);
    chk("empty_w0", cap32[0], 64'h80000000);
    chk("empty_w15", cap32[15], 64'h0);

    $display("[TB] 56 bytes");
    cap32.delete();
    applyStimulus(makeMsg(56), 32, 1'b0);
    waitDrain(0);
    chk("b56_words", 64'(cap32.size()), 64'd32);
    chk("b56_term", cap32[14], 64'h80000000);
    chk("b56_len", cap32[31], 64'h1C0);

    $display("[TB] 52, 55 and 60 bytes");
    applyStimulus(makeMsg(52), 32, 1'b0);
    waitDrain(0);
    applyStimulus(makeMsg(55), 32, 1'b0);
    waitDrain(0);
    applyStimulus(makeMsg(60), 32, 1'b0);
    waitDrain(0);

    $display("[TB] 64 bytes");
    cap32.delete();
    applyStimulus(makeMsg(64), 32, 1'b0);
    waitDrain(0);
    chk("b64_term", cap32[16], 64'h80000000);
    chk("b64_len", cap32[31], 64'h200);

    $display("[TB] abc, 64-bit");
    cap64.delete();
    applyStimulus(abc, 64, 1'b0);
    waitDrain(1);
    chk("abc64_w0", cap64[0], 64'h6162638000000000);
    chk("abc64_w15", cap64[15], 64'h18);

    $display("[TB] random ready with input gaps");
    rand_ready = 1'b1;
    cap32.delete();
    applyStimulus(abc, 32, 1'b1);
    waitDrain(0);
    applyStimulus(makeMsg(70), 32, 1'b1);
    waitDrain(0);
    rand_ready = 1'b0;
    @(posedge clk); #2;
    chk("rand_abc_w0", cap32[0], 64'h61626380);

    $display("[TB] abort on drain word 5");
    base = xfer[0];
    applyStimulus(abc, 32, 1'b0);
    for (int n = 0; n < 100 && xfer[0] < base + 5; n++) begin
      @(posedge clk); #2;
    end
    chk("abort_reached_word5", 64'(xfer[0] - base), 64'd5);
    abort_i = 1'b1;
    @(posedge clk); #2;
    abort_i = 1'b0;
    @(negedge clk);
    chk("abort_data_valid", 64'(dvalid32), 64'd0);
    chk("abort_in_ready", 64'(in_ready32), 64'd1);
    @(posedge clk); #2;
    cap32.delete();
    applyStimulus(abc, 32, 1'b0);
    waitDrain(0);
    chk("post_abort_w15", cap32[15], 64'h18);

    $display("[TB] reset during fill");
    sendWord(32, 64'h11111111, 1'b0, 4);
    sendWord(32, 64'h22222222, 1'b0, 4);
    sendWord(32, 64'h33333333, 1'b0, 4);
    reset_i = 1'b1;
    @(posedge clk); #2;
    reset_i = 1'b0;
    @(negedge clk);
    checkIdle("midreset");
    @(posedge clk); #2;
    cap32.delete();
    applyStimulus(abc, 32, 1'b0);
    waitDrain(0);
    chk("post_reset_w0", cap32[0], 64'h61626380);
    chk("post_reset_w15", cap32[15], 64'h18);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
